// File: rtl/mc_control_fsm.sv
// Multi-cycle RV32I control unit: sequences fetch/decode/execute/memory/writeback and
// drives datapath muxes, write enables and memory requests, with a memory-wait timeout.
module mc_control_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter int unsigned TIMEOUT_W      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ack,
  output logic [2:0] imm_type,
  output logic       ir_write,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_src,
  output logic       mem_req,
  output logic       mem_we,
  output logic       reg_write,
  output logic [1:0] wb_sel,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic       illegal_op,
  output logic       bus_err,
  output logic [3:0] state_dbg
);

  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpRType  = 7'b0110011;
  localparam logic [6:0] OpIType  = 7'b0010011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;

  localparam logic [TIMEOUT_W-1:0] CntLast = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [3:0] {
    StFetch   = 4'd0,
    StDecode  = 4'd1,
    StMemAddr = 4'd2,
    StMemRd   = 4'd3,
    StMemWb   = 4'd4,
    StMemWr   = 4'd5,
    StExecR   = 4'd6,
    StExecI   = 4'd7,
    StAluWb   = 4'd8,
    StBranch  = 4'd9,
    StJal     = 4'd10,
    StJalr    = 4'd11,
    StLui     = 4'd12,
    StAuipc   = 4'd13,
    StError   = 4'd14,
    StInit    = 4'd15
  } state_e;

  state_e               state_q, state_d;
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
  logic                 wait_st;
  logic                 timeout;

  // Only these states wait on the memory; mem_ack is ignored elsewhere.
  assign wait_st = (state_q == StFetch) || (state_q == StMemRd) || (state_q == StMemWr);
  assign timeout = wait_st && !mem_ack && (cnt_q == CntLast);
  assign state_dbg = state_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StInit;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StInit:    state_d = StFetch;
      StFetch:   if (mem_ack) state_d = StDecode;
      StDecode: begin
        case (opcode)
          OpLoad, OpStore: state_d = StMemAddr;
          OpRType:         state_d = StExecR;
          OpIType:         state_d = StExecI;
          OpBranch:        state_d = StBranch;
          OpJal:           state_d = StJal;
          OpJalr:          state_d = StJalr;
          OpLui:           state_d = StLui;
          OpAuipc:         state_d = StAuipc;
          default:         state_d = StError;
        endcase
      end
      StMemAddr: state_d = (opcode == OpLoad) ? StMemRd : StMemWr;
      StMemRd:   if (mem_ack) state_d = StMemWb;
      StMemWr:   if (mem_ack) state_d = StFetch;
      StExecR, StExecI, StAuipc: state_d = StAluWb;
      StMemWb, StAluWb, StBranch, StJal, StJalr, StLui: state_d = StFetch;
      StError:   state_d = StError;
      default:   state_d = StError;
    endcase
    if (timeout) state_d = StError;

    cnt_d = cnt_q;
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (wait_st && !mem_ack) begin
      cnt_d = cnt_q + TIMEOUT_W'(1);
    end
  end

  always_comb begin
    case (opcode)
      OpLoad, OpIType, OpJalr: imm_type = 3'b000;
      OpStore:                 imm_type = 3'b010;
      OpBranch:                imm_type = 3'b011;
      OpJal:                   imm_type = 3'b100;
      OpLui, OpAuipc:          imm_type = 3'b101;
      default:                 imm_type = 3'b000;
    endcase
  end

  always_comb begin
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    reg_write     = 1'b0;
    wb_sel        = 2'b00;
    alu_src_a     = 2'b00;
    alu_src_b     = 2'b00;
    alu_op        = 2'b00;
    illegal_op    = 1'b0;
    bus_err       = timeout;
    unique case (state_q)
      StFetch: begin
        mem_req   = 1'b1;
        alu_src_b = 2'b01;
        ir_write  = mem_ack;
        pc_write  = mem_ack;
      end
      StDecode: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      StMemAddr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
      end
      StMemRd:   mem_req = 1'b1;
      StMemWb: begin
        reg_write = 1'b1;
        wb_sel    = 2'b01;
      end
      StMemWr: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
      end
      StExecR: begin
        alu_src_a = 2'b01;
        alu_op    = 2'b10;
      end
      StExecI: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        alu_op    = 2'b11;
      end
      StAuipc: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b10;
      end
      StAluWb:   reg_write = 1'b1;
      StBranch: begin
        alu_src_a     = 2'b01;
        alu_op        = 2'b01;
        pc_write_cond = 1'b1;
        pc_src        = 2'b01;
      end
      StJal: begin
        pc_write  = 1'b1;
        pc_src    = 2'b01;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
      end
      StJalr: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        pc_src    = 2'b10;
        reg_write = 1'b1;
        wb_sel    = 2'b10;
      end
      StLui: begin
        reg_write = 1'b1;
        wb_sel    = 2'b11;
      end
      StError:   illegal_op = 1'b1;
      StInit:    ;
      default:   ;
    endcase
  end

endmodule
